reduct_arb: RTL



---
 rtl/reduct_pkg.sv | 15 +
 rtl/reduct.sv | 30 +++
 rtl/rr_arbiter.sv | 32 +++
 rtl/reduct_arb.sv | 99 +++++++++
 4 files changed

// File: rtl/reduct_pkg.sv
// rtl/reduct_pkg.sv - shared types and helpers for the reduct arbiter
package reduct_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    // Index width for n requesters; a single requester still gets one bit.
    function automatic int idw(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/reduct.sv
// rtl/reduct.sv - bitwise reduction of IN words into one DATA-wide word
module reduct #(
    parameter string OPE  = "or",
    parameter bit    NOT  = 1'b0,
    parameter int    IN   = 4,
    parameter int    DATA = 16
) (
    input  logic [IN-1:0][DATA-1:0] in,
    output logic [DATA-1:0]         out
);

    localparam bit IS_AND = (OPE == "and");
    localparam bit IS_OR  = (OPE == "or");
    localparam bit IS_XOR = (OPE == "xor");

    logic [DATA-1:0] acc;

    // Fold every word with the chosen operator; unknown operators give zero.
    always_comb begin
        acc = IS_AND ? '1 : '0;
        for (int i = 0; i < IN; i++) begin
            if (IS_AND)      acc = acc & in[i];
            else if (IS_OR)  acc = acc | in[i];
            else if (IS_XOR) acc = acc ^ in[i];
        end
        if (IS_AND || IS_OR || IS_XOR) out = NOT ? ~acc : acc;
        else                           out = '0;
    end

endmodule

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin grant search
module rr_arbiter
    import reduct_pkg::*;
#(
    parameter int  REQ = 4,
    localparam int IDW = idw(REQ)
) (
    input  logic [REQ-1:0] req,
    input  logic [IDW-1:0] ptr,
    output logic [REQ-1:0] grant,
    output logic [IDW-1:0] idx,
    output logic           any
);

    // Scan REQ slots starting at ptr and wrapping; the first active slot wins.
    always_comb begin
        int slot;
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        slot  = 0;
        for (int i = 0; i < REQ; i++) begin
            slot = (int'(ptr) + i) % REQ;
            if (!any && req[slot]) begin
                any         = 1'b1;
                grant[slot] = 1'b1;
                idx         = IDW'(slot);
            end
        end
    end

endmodule

// File: rtl/reduct_arb.sv
// rtl/reduct_arb.sv - round-robin sequencer sharing one reduct datapath
module reduct_arb
    import reduct_pkg::*;
#(
    parameter string OPE  = "or",
    parameter bit    NOT  = 1'b0,
    parameter int    REQ  = 4,
    parameter int    IN   = 4,
    parameter int    DATA = 16,
    localparam int   IDW  = idw(REQ)
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [REQ-1:0]                 req_valid,
    input  logic [REQ-1:0][IN-1:0][DATA-1:0] req_data,
    output logic [REQ-1:0]                 req_ready,
    output logic                           rsp_valid,
    output logic [IDW-1:0]                 rsp_id,
    output logic [DATA-1:0]                rsp_data,
    input  logic                           rsp_ready,
    output logic                           busy
);

    state_t                  state, state_nxt;
    logic [IDW-1:0]          rr_ptr, cur_id, gnt_idx;
    logic [REQ-1:0]          gnt;
    logic                    gnt_any;
    logic                    accept;
    logic [IN-1:0][DATA-1:0] opnd;
    logic [DATA-1:0]         red_out;

    rr_arbiter #(.REQ(REQ)) u_arb (
        .req   (req_valid),
        .ptr   (rr_ptr),
        .grant (gnt),
        .idx   (gnt_idx),
        .any   (gnt_any)
    );

    reduct #(.OPE(OPE), .NOT(NOT), .IN(IN), .DATA(DATA)) u_reduct (
        .in  (opnd),
        .out (red_out)
    );

    assign accept = (state == IDLE) && gnt_any;
    assign busy   = (state != IDLE);

    // Next state and accept strobe; reset masks req_ready so no request looks accepted.
    always_comb begin
        state_nxt = state;
        req_ready = '0;
        case (state)
            IDLE: begin
                if (gnt_any && !reset) begin
                    req_ready = gnt;
                    state_nxt = EXEC;
                end
            end
            EXEC:    state_nxt = RESP;
            RESP:    if (rsp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // On accept capture the operands and requester id, and move the pointer past the winner.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_ptr <= '0;
            cur_id <= '0;
            opnd   <= '0;
        end else if (accept) begin
            opnd   <= req_data[gnt_idx];
            cur_id <= gnt_idx;
            rr_ptr <= (gnt_idx == IDW'(REQ - 1)) ? '0 : gnt_idx + 1'b1;
        end
    end

    // Result register: load in EXEC, hold through backpressure, drop valid on handshake.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_data  <= '0;
        end else if (state == EXEC) begin
            rsp_valid <= 1'b1;
            rsp_id    <= cur_id;
            rsp_data  <= red_out;
        end else if (state == RESP && rsp_ready) begin
            rsp_valid <= 1'b0;
        end
    end

endmodule
